// File: rtl/csi2tx_dw_payload_fifo_if.sv
// csi2tx_dw_payload_fifo_if
//   Groups the converter-side payload strobe and the consumer-side
//   ready/valid handshake of the CSI-2 TX payload FIFO.
//   Converter side : dw_in, dw_vld_in, eol_in      (no back-pressure)
//   Consumer side  : pld_dw, pld_last, pld_vld, pld_rdy
//   Modports       : slave  - the FIFO itself
//                    master - the environment driving/consuming it
interface csi2tx_dw_payload_fifo_if;
  logic [31:0] dw_in;
  logic        dw_vld_in;
  logic        eol_in;
  logic [31:0] pld_dw;
  logic        pld_last;
  logic        pld_vld;
  logic        pld_rdy;

  modport slave (
    input  dw_in, dw_vld_in, eol_in, pld_rdy,
    output pld_dw, pld_last, pld_vld
  );

  modport master (
    output dw_in, dw_vld_in, eol_in, pld_rdy,
    input  pld_dw, pld_last, pld_vld
  );
endinterface

// File: rtl/csi2tx_dw_payload_fifo.sv
// csi2tx_dw_payload_fifo
//   FWFT payload FIFO between the CSI-2 TX pixel-to-byte converters and the
//   lane distributor. Stores 32-bit words plus a last-of-line tag, counts the
//   bytes of each line and publishes the Word Count when the eol word arrives.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   pld_if    - converter input strobe and consumer ready/valid (slave side)
//   flush     - synchronous clear of pointers, counters and flags
//   wc/wc_vld - byte count of the last completed line, one-cycle update pulse
//   fill/full - registered occupancy and full flag
//   ovf       - sticky flag: at least one word was dropped
module csi2tx_dw_payload_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  csi2tx_dw_payload_fifo_if.slave      pld_if,
  input  logic                         flush,
  output logic [15:0]                  wc,
  output logic                         wc_vld,
  output logic [AW:0]                  fill,
  output logic                         full,
  output logic                         ovf
);

  localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]  ONE_C    = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0]  CNT_MAX  = 16'hFFFC;

  logic [32:0] mem_r [DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] fill_r, fill_nxt_s;
  logic        full_r, ovf_r, wc_vld_r;
  logic [15:0] cnt_r, wc_r, cnt_sat_s;
  logic        empty_s, full_s, rd_s, wr_s;
  logic [32:0] head_s;

  // Pointer-derived status: equal pointers mean empty, MSB differing with
  // equal low bits means full.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_s    = !empty_s && pld_if.pld_rdy;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_s    = pld_if.dw_vld_in && (!full_s || rd_s);
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

  // Next occupancy and saturating byte count for the current cycle.
  always_comb begin
    fill_nxt_s = fill_r;
    case ({wr_s, rd_s})
      2'b10:   fill_nxt_s = fill_r + ONE_C;
      2'b01:   fill_nxt_s = fill_r - ONE_C;
      default: fill_nxt_s = fill_r;
    endcase
    if (cnt_r >= CNT_MAX) begin
      cnt_sat_s = CNT_MAX;
    end else begin
      cnt_sat_s = cnt_r + 16'd4;
    end
  end

  // FWFT head presentation; zeroed when empty so stale storage never leaks.
  always_comb begin
    if (empty_s) begin
      pld_if.pld_dw   = 32'd0;
      pld_if.pld_last = 1'b0;
    end else begin
      pld_if.pld_dw   = head_s[31:0];
      pld_if.pld_last = head_s[32];
    end
    pld_if.pld_vld = !empty_s;
  end

  // Payload storage; not reset, validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (wr_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {pld_if.eol_in, pld_if.dw_in};
    end
  end

  // Pointers, flags, line byte counter and word-count publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= 16'd0;
      wc_r     <= 16'd0;
      wc_vld_r <= 1'b0;
    end else if (flush) begin
      // wc deliberately survives a flush; the header builder may still need it.
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= 16'd0;
      wc_vld_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      fill_r <= fill_nxt_s;
      full_r <= (fill_nxt_s == DEPTH_C);
      if (pld_if.dw_vld_in && !wr_s) begin
        ovf_r <= 1'b1;
      end
      if (pld_if.dw_vld_in && pld_if.eol_in) begin
        // A dropped eol word contributes no bytes to the published count.
        wc_r     <= wr_s ? cnt_sat_s : cnt_r;
        cnt_r    <= 16'd0;
        wc_vld_r <= 1'b1;
      end else begin
        if (wr_s) begin
          cnt_r <= cnt_sat_s;
        end
        wc_vld_r <= 1'b0;
      end
    end
  end

  assign wc     = wc_r;
  assign wc_vld = wc_vld_r;
  assign fill   = fill_r;
  assign full   = full_r;
  assign ovf    = ovf_r;

endmodule
